fib_seq_gen: RTL and testbench
==============================

# fib_seq_gen

Parametrised, synthesisable Fibonacci-class sequence generator with a valid/ready output stream.
- A `start` pulse loads two seeds and a term count.
- The block then streams the terms term(i+2) = term(i+1) + term(i) on `term`, each with its index.
- Generation stops at the requested count, or early when the next term would overflow `WIDTH`.
- It replaces the free-running, fixed-width testbench-style generator and sits as a stimulus/pattern source feeding downstream datapath blocks.

## Interface
Parameters:
- `WIDTH`, 32, bit width of seeds and terms.
- `CNT_W`, 8, bit width of term count and index.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  request a new sequence; sampled only in IDLE.
- `n_terms`  in  CNT_W  number of terms to emit; captured on accepted `start`.
- `seed0`  in  WIDTH  term 0; captured on accepted `start`.
- `seed1`  in  WIDTH  term 1; captured on accepted `start`.
- `out_ready`  in  1  downstream accepts current term.
- `out_valid`  out  1  `term`/`index`/`last` are valid.
- `term`  out  WIDTH  current sequence term.
- `index`  out  CNT_W  index of current term, 0-based.
- `last`  out  1  current term is the final one emitted.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse after the final handshake, or after a zero-length request.
- `overflow`  out  1  sticky: the sequence ended early because the next term exceeded WIDTH.

## Operation
- State machine: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 captures the seeds and `n_terms` and clears `overflow`.
  - Internal state loads a=`seed0`, b=`seed1`, b_ovf=0, index=0.
  - If `n_terms`=0, go to FIN; else go to RUN.
- RUN:
  - `out_valid`=1, `term`=a, `index`=idx.
  - `last` = (idx == `n_terms`-1) OR b_ovf. For `n_terms`=1, `last`=1 on term 0.
  - On handshake (`out_valid` & `out_ready`) with `last`=0:
    - a<=b, {c,b}<=a+b computed at WIDTH+1 bits, b_ovf<=c, idx<=idx+1.
  - On handshake with `last`=1: go to FIN; `overflow` <= b_ovf & (idx != `n_terms`-1).
  - With `out_valid`=1 and `out_ready`=0, `term`/`index`/`last` are held stable. No term is dropped or skipped.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or FIN is ignored; there is no queuing.
- The overflow check is exact: b_ovf is set only by carry-out of the WIDTH-bit add. No term with a wrapped value is ever emitted.
- `index` never wraps, because generation stops at `n_terms`-1 ≤ 2^CNT_W-2.
- `busy` = (state != IDLE).
- Reset (asynchronous, any state, including mid-run with `out_valid`=1):
  - State returns to IDLE.
  - `out_valid`, `last`, `busy`, `done`, `overflow` go to 0; `term` and `index` go to 0.
  - Internal a, b, idx, b_ovf are cleared.
- Reset release: first `start` is accepted on the first rising edge with `rst`=0.

## Timing
- Accepted `start` at edge k: `out_valid`=1 with term 0 from edge k+1.
- With `out_ready` tied high: one term per cycle; term i is presented in cycle k+1+i.
- Final handshake at edge m: `done`=1 and `busy`=1 in cycle m+1. In cycle m+2: IDLE, `busy`=0, `done`=0.
- `n_terms`=0: start at edge k gives `done` in cycle k+1, `out_valid` never asserts.
- `overflow` is valid from the `done` cycle and holds until the next accepted `start` or reset.
- All outputs are registered. There is no combinational path from `out_ready` to `out_valid` or `term`.
- A new `start` is accepted earliest in the cycle after `done`: back-to-back gap of 1 idle cycle.

## Test plan
- WIDTH=32, seeds 0/1, `n_terms`=10, `out_ready`=1:
  - Terms 0,1,1,2,3,5,8,13,21,34 in consecutive cycles, with `index` 0..9.
  - `last` on 34 only; `done` the next cycle; `overflow`=0.
- Same request with `out_ready` toggling 1,0,0,1,…:
  - Identical term/index sequence; outputs held stable during stalls.
  - Exactly 10 handshakes, `done` once.
- WIDTH=8, seeds 0/1, `n_terms`=20:
  - Emits 0..233 (14 terms, index 0..13), `last` on 233 (index 13).
  - `done` next cycle, `overflow`=1; no value ≥256 or wrapped value appears.
- Lucas seeds 2/1, `n_terms`=5 → 2,1,3,4,7. `n_terms`=1 → single term 2 with `last`=1. `n_terms`=0 → `done` one cycle after start, no `out_valid`.
- Assert `start` with seeds 5/5 at index 3 of a running sequence:
  - The running sequence is unaffected.
  - The `start` is ignored; after `done`, a fresh `start` with seeds 5/5 yields 5,5,10.
  - `overflow` is cleared by that start.
- Assert `rst` mid-run at index 4 while stalled:
  - All outputs drop to 0 asynchronously, before the next clock edge.
  - After release, `start` 0/1 with `n_terms`=3 → 0,1,1, with `done` one cycle after the last handshake.

Source files
------------

// File: rtl/fib_seq_if.sv
// Request/stream bundle for the Fibonacci-class sequence generator.
// The slave side is the generator; the master side issues requests and consumes terms.
interface fib_seq_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] term;
  logic [CNT_W-1:0] index;
  logic             last;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, n_terms, seed0, seed1, out_ready,
    input  out_valid, term, index, last, busy, done, overflow
  );

  modport slave (
    input  start, n_terms, seed0, seed1, out_ready,
    output out_valid, term, index, last, busy, done, overflow
  );
endinterface

// File: rtl/fib_seq_gen.sv
// Seeded Fibonacci-class term generator with a valid/ready stream; it stops at the
// requested count or just before a term would overflow WIDTH. All outputs are flops.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  fib_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt, b, b_nxt;
  logic             b_ovf, b_ovf_nxt;
  logic [CNT_W-1:0] idx, idx_nxt, n_cap, n_cap_nxt;
  logic             last, last_nxt, ovf, ovf_nxt;
  logic             valid, done, busy;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] idx_inc, last_idx;
  logic             hs;

  // Carry of the WIDTH+1 bit add is the exact overflow flag for the term after b.
  assign sum      = {1'b0, a} + {1'b0, b};
  assign idx_inc  = idx + ONE;
  assign last_idx = n_cap - ONE;
  assign hs       = valid & bus.out_ready;

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    b_ovf_nxt = b_ovf;
    idx_nxt   = idx;
    n_cap_nxt = n_cap;
    last_nxt  = last;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.seed0;
          b_nxt     = bus.seed1;
          b_ovf_nxt = 1'b0;
          idx_nxt   = ZERO;
          n_cap_nxt = bus.n_terms;
          ovf_nxt   = 1'b0;
          last_nxt  = (bus.n_terms == ONE);
          state_nxt = (bus.n_terms == ZERO) ? FIN : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (hs && last) begin
          state_nxt = FIN;
          last_nxt  = 1'b0;
          ovf_nxt   = b_ovf & (idx != last_idx);
        end else if (hs) begin
          a_nxt                = b;
          {b_ovf_nxt, b_nxt}   = sum;
          idx_nxt              = idx_inc;
          last_nxt             = (idx_inc == last_idx) | sum[WIDTH];
        end else begin
          state_nxt = RUN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= {WIDTH{1'b0}};
      b     <= {WIDTH{1'b0}};
      b_ovf <= 1'b0;
      idx   <= ZERO;
      n_cap <= ZERO;
      last  <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      b_ovf <= b_ovf_nxt;
      idx   <= idx_nxt;
      n_cap <= n_cap_nxt;
      last  <= last_nxt;
      ovf   <= ovf_nxt;
      valid <= (state_nxt == RUN);
      done  <= (state_nxt == FIN);
      busy  <= (state_nxt != IDLE);
    end
  end

  assign bus.out_valid = valid;
  assign bus.term      = a;
  assign bus.index     = idx;
  assign bus.last      = last;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench: directed requests push hand-computed terms; per-DUT monitors
// compare every presented term against the queue head and pop on handshake.
module tb_fib_seq_gen;
  typedef struct packed {
    logic [31:0] term;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   ready_mode;
  int   phase;
  int   done_cnt [2];
  int   hs_cyc   [2];
  exp_t q32 [$];
  exp_t q8  [$];
  logic [31:0] vals [$];

  fib_seq_if #(.WIDTH(32), .CNT_W(8)) b32 ();
  fib_seq_if #(.WIDTH(8),  .CNT_W(8)) b8 ();

  fib_seq_gen #(.WIDTH(32), .CNT_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  fib_seq_gen #(.WIDTH(8),  .CNT_W(8)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Ready driver for the 32-bit stream: 0 = always ready, 1 = pattern 1,0,0, 2 = manual.
  initial begin
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) b32.out_ready = 1'b1;
      else if (ready_mode == 1) begin
        b32.out_ready = (phase % 3 == 0);
        phase++;
      end
    end
  end

  // Scoreboard monitor, 32-bit DUT.
  always @(negedge clk) begin
    if (b32.done) begin
      done_cnt[0]++;
      chk("done_timing32", cyc, hs_cyc[0] + 1);
      chk("busy_at_done32", b32.busy, 1'b1);
    end
    if (b32.out_valid) begin
      if (q32.size() == 0) chk("unexpected_term32", b32.out_valid, 1'b0);
      else begin
        chk("term32", b32.term, q32[0].term);
        chk("index32", b32.index, q32[0].idx);
        chk("last32", b32.last, q32[0].last);
        if (b32.out_ready) begin
          if (q32[0].last) hs_cyc[0] = cyc;
          void'(q32.pop_front());
        end
      end
    end
  end

  // Scoreboard monitor, 8-bit DUT.
  always @(negedge clk) begin
    if (b8.done) begin
      done_cnt[1]++;
      chk("done_timing8", cyc, hs_cyc[1] + 1);
    end
    if (b8.out_valid) begin
      if (q8.size() == 0) chk("unexpected_term8", b8.out_valid, 1'b0);
      else begin
        chk("term8", {24'd0, b8.term}, q8[0].term);
        chk("index8", b8.index, q8[0].idx);
        chk("last8", b8.last, q8[0].last);
        if (b8.out_ready) begin
          if (q8[0].last) hs_cyc[1] = cyc;
          void'(q8.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input bit w8);
    exp_t e;
    for (int i = 0; i < vals.size(); i++) begin
      e.term = vals[i];
      e.idx  = 8'(i);
      e.last = (i == vals.size() - 1);
      if (w8) q8.push_back(e);
      else q32.push_back(e);
    end
  endtask

  task automatic start_seq(input bit w8, input logic [31:0] s0, input logic [31:0] s1, input logic [7:0] n);
    if (w8) begin
      b8.start = 1'b1; b8.seed0 = s0[7:0]; b8.seed1 = s1[7:0]; b8.n_terms = n;
    end else begin
      b32.start = 1'b1; b32.seed0 = s0; b32.seed1 = s1; b32.n_terms = n;
    end
    @(posedge clk);
    #1;
    b8.start  = 1'b0;
    b32.start = 1'b0;
    if (n == 8'd0) hs_cyc[w8] = cyc - 1;
    @(negedge clk);
    chk("first_valid", w8 ? b8.out_valid : b32.out_valid, (n != 8'd0));
  endtask

  task automatic wait_done(input bit w8, input logic exp_ovf);
    int c0;
    int i;
    c0 = done_cnt[w8];
    i  = 0;
    while (done_cnt[w8] == c0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", (done_cnt[w8] != c0), 1'b1);
    repeat (2) @(negedge clk);
    chk("done_once", done_cnt[w8] - c0, 1);
    chk("busy_idle", w8 ? b8.busy : b32.busy, 1'b0);
    chk("overflow", w8 ? b8.overflow : b32.overflow, exp_ovf);
    chk("all_terms_seen", w8 ? q8.size() : q32.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    n_checks = 0; n_fail = 0; cyc = 0; ready_mode = 0;
    done_cnt[0] = 0; done_cnt[1] = 0; hs_cyc[0] = 0; hs_cyc[1] = 0;
    rst = 1'b1;
    b32.start = 1'b0; b32.seed0 = 32'd0; b32.seed1 = 32'd0; b32.n_terms = 8'd0; b32.out_ready = 1'b1;
    b8.start  = 1'b0; b8.seed0  = 8'd0;  b8.seed1  = 8'd0;  b8.n_terms  = 8'd0; b8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", b32.out_valid, 1'b0);
    chk("rst_busy", b32.busy, 1'b0);
    chk("rst_term", b32.term, 32'd0);
    chk("rst_ovf", b32.overflow, 1'b0);
    rst = 1'b0;

    // Plain Fibonacci, always ready, then the same request with stalls.
    vals = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    push_exp(1'b0);
    start_seq(1'b0, 32'd0, 32'd1, 8'd10);
    wait_done(1'b0, 1'b0);
    ready_mode = 1;
    push_exp(1'b0);
    start_seq(1'b0, 32'd0, 32'd1, 8'd10);
    wait_done(1'b0, 1'b0);
    ready_mode = 0;

    // 8-bit terms stop early at 233.
    vals = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34,
             32'd55, 32'd89, 32'd144, 32'd233};
    push_exp(1'b1);
    start_seq(1'b1, 32'd0, 32'd1, 8'd20);
    wait_done(1'b1, 1'b1);

    // Lucas seeds, counts 5, 1, 0.
    vals = '{32'd2, 32'd1, 32'd3, 32'd4, 32'd7};
    push_exp(1'b0);
    start_seq(1'b0, 32'd2, 32'd1, 8'd5);
    wait_done(1'b0, 1'b0);
    vals = '{32'd2};
    push_exp(1'b0);
    start_seq(1'b0, 32'd2, 32'd1, 8'd1);
    wait_done(1'b0, 1'b0);
    start_seq(1'b0, 32'd2, 32'd1, 8'd0);
    chk("zero_len_done", b32.done, 1'b1);
    wait_done(1'b0, 1'b0);

    // Overflowing 32-bit run with an ignored start at index 3.
    vals = '{32'h2000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000, 32'hA000_0000};
    push_exp(1'b0);
    start_seq(1'b0, 32'h2000_0000, 32'h2000_0000, 8'd10);
    i = 0;
    while (!(b32.out_valid && b32.index == 8'd3) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("reach_index3", b32.index, 8'd3);
    b32.start = 1'b1; b32.seed0 = 32'd5; b32.seed1 = 32'd5; b32.n_terms = 8'd3;
    @(negedge clk);
    b32.start = 1'b0;
    wait_done(1'b0, 1'b1);
    vals = '{32'd5, 32'd5, 32'd10};
    push_exp(1'b0);
    start_seq(1'b0, 32'd5, 32'd5, 8'd3);
    wait_done(1'b0, 1'b0);

    // Asynchronous reset while stalled at index 4.
    ready_mode = 2;
    b32.out_ready = 1'b1;
    vals = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    push_exp(1'b0);
    start_seq(1'b0, 32'd0, 32'd1, 8'd10);
    repeat (4) @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_index4", b32.index, 8'd4);
    chk("stall_valid", b32.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", b32.out_valid, 1'b0);
    chk("arst_term", b32.term, 32'd0);
    chk("arst_index", b32.index, 8'd0);
    chk("arst_busy", b32.busy, 1'b0);
    chk("arst_last", b32.last, 1'b0);
    q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    b32.out_ready = 1'b1;
    ready_mode = 0;
    vals = '{32'd0, 32'd1, 32'd1};
    push_exp(1'b0);
    start_seq(1'b0, 32'd0, 32'd1, 8'd3);
    wait_done(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
